// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types and decode constants for core_sequencer.
//   seq_state_e  : sequencer FSM states
//   flow_e       : classification of a fetched word
//   decode_flow(): maps a 16-bit instruction word to flow_e
package core_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_HALT
   } seq_state_e;

   typedef enum logic [2:0] {
      FL_NONE,
      FL_BRZ,
      FL_BRN,
      FL_CALL,
      FL_RET,
      FL_JMPR,
      FL_HALT
   } flow_e;

   localparam logic [1:0]  GRP_FLOW  = 2'b10;
   localparam logic [2:0]  OP3_BRZ   = 3'b110;
   localparam logic [2:0]  OP3_BRN   = 3'b111;
   localparam logic [4:0]  OP5_JMPR  = 5'b01101;
   localparam logic [4:0]  OP5_CALL  = 5'b01110;
   localparam logic [4:0]  OP5_RET   = 5'b01111;
   localparam logic [15:0] HALT_WORD = 16'hFFFF;

   // Branch op3 codes (11x) cannot collide with the 011xx op5 prefix of
   // CALL/RET/JMPR, so the checks can be tried in any order.
   function automatic flow_e decode_flow(input logic [15:0] w);
      decode_flow = FL_NONE;
      if (w == HALT_WORD) begin
         decode_flow = FL_HALT;
      end else if (w[15:14] == GRP_FLOW) begin
         if (w[13:11] == OP3_BRZ)      decode_flow = FL_BRZ;
         else if (w[13:11] == OP3_BRN) decode_flow = FL_BRN;
         else if (w[13:9] == OP5_CALL) decode_flow = FL_CALL;
         else if (w[13:9] == OP5_RET)  decode_flow = FL_RET;
         else if (w[13:9] == OP5_JMPR) decode_flow = FL_JMPR;
      end
   endfunction

endpackage

// File: rtl/seq_ret_stack.sv
// seq_ret_stack: return-address LIFO for core_sequencer.
//   clock_50     in  : clock
//   reset_n      in  : synchronous active-low reset (empties the stack)
//   push_i       in  : push push_data_i (ignored when full)
//   pop_i        in  : pop top entry (ignored when empty)
//   push_data_i  in  : return address to push
//   pop_data_o   out : current top-of-stack entry
//   full_o       out : STACK_DEPTH entries held
//   empty_o      out : no entries held
module seq_ret_stack #(
   parameter int STACK_DEPTH = 8,
   parameter int PC_W        = 8
) (
   input  logic            clock_50,
   input  logic            reset_n,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic [PC_W-1:0] push_data_i,
   output logic [PC_W-1:0] pop_data_o,
   output logic            full_o,
   output logic            empty_o
);

   localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
   localparam int IDX_W = SP_W - 1;

   logic [PC_W-1:0]  mem_q [STACK_DEPTH];
   logic [SP_W-1:0]  sp_q;
   logic [IDX_W-1:0] top_idx;

   assign full_o     = (sp_q == SP_W'(STACK_DEPTH));
   assign empty_o    = (sp_q == '0);
   assign top_idx    = sp_q[IDX_W-1:0] - IDX_W'(1);
   assign pop_data_o = mem_q[top_idx];

   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         sp_q <= '0;
      end else if (push_i && !full_o) begin
         sp_q <= sp_q + SP_W'(1);
      end else if (pop_i && !empty_o) begin
         sp_q <= sp_q - SP_W'(1);
      end
   end

   // Entry storage needs no reset: only slots below sp_q are ever read.
   always_ff @(posedge clock_50) begin
      if (reset_n && push_i && !full_o) begin
         mem_q[sp_q[IDX_W-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer: fetches instruction words over a req/ack handshake, runs
// flow control (BRZ, BRN, CALL, RET, JMPR, HALT) locally and hands every
// other word to the core through IR / ir_valid.
//   clock_50, reset_n (sync, active-low), run
//   step        in  : single-step pulse, only with SEQ_SINGLE_STEP_EN defined
//   imem_req/imem_addr out, imem_rdata/imem_ack in : instruction fetch
//   IR, ir_valid out : issued instruction and its one-cycle strobe
//   Z, N in          : core flags, sampled the cycle after an issue
//   rd_sel out, rd_data in : core register read for CALL/JMPR targets
//   pc, halted, stack_err out
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run (or step)
// FETCH  | imem_req high at imem_addr=pc until imem_ack
// DECODE | flow word applied here; core word moves on to ISSUE
// ISSUE  | ir_valid high for one cycle, pc advances
// HALT   | HALT word or stack fault, left only by reset
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int STACK_DEPTH = 8
) (
   input  logic            clock_50,
   input  logic            reset_n,
   input  logic            run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic            step,
`endif
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   input  logic            imem_ack,
   output logic [15:0]     IR,
   output logic            ir_valid,
   input  logic            Z,
   input  logic            N,
   output logic [2:0]      rd_sel,
   input  logic [15:0]     rd_data,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            stack_err
);

   seq_state_e      state_q;
   logic [PC_W-1:0] pc_q;
   logic [15:0]     ir_q;
   logic            req_q, ir_valid_q, halted_q, stack_err_q;
   logic [2:0]      rd_sel_q;
   logic            z_q, n_q, flag_pend_q;

   flow_e           flow;
   logic [PC_W-1:0] pc_inc, br_target, flow_pc_d, pop_data;
   logic            stk_full, stk_empty, stk_fault, push, pop;
   logic            start, cont;
   logic            unused_rd;

   assign unused_rd = ^rd_data;

`ifdef SEQ_SINGLE_STEP_EN
   // step_q marks an instruction started by a step pulse so that it
   // returns to IDLE afterwards regardless of run.
   logic step_q;

   always_ff @(posedge clock_50) begin
      if (!reset_n)                 step_q <= 1'b0;
      else if (state_q == ST_IDLE)  step_q <= ~run & step;
   end

   assign start = run | step;
   assign cont  = run & ~step_q;
`else
   assign start = run;
   assign cont  = run;
`endif

   assign flow      = decode_flow(ir_q);
   assign pc_inc    = pc_q + PC_W'(1);
   assign br_target = pc_inc + PC_W'($signed(ir_q[7:0]));
   assign push      = (state_q == ST_DECODE) && (flow == FL_CALL);
   assign pop       = (state_q == ST_DECODE) && (flow == FL_RET);
   assign stk_fault = (push && stk_full) || (pop && stk_empty);

   always_comb begin
      flow_pc_d = pc_inc;
      case (flow)
         FL_BRZ:           if (z_q) flow_pc_d = br_target;
         FL_BRN:           if (n_q) flow_pc_d = br_target;
         FL_CALL, FL_JMPR: flow_pc_d = rd_data[PC_W-1:0];
         FL_RET:           flow_pc_d = pop_data;
         default:          ;
      endcase
   end

   seq_ret_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .PC_W        (PC_W)
   ) u_stack (
      .clock_50    (clock_50),
      .reset_n     (reset_n),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (pc_inc),
      .pop_data_o  (pop_data),
      .full_o      (stk_full),
      .empty_o     (stk_empty)
   );

   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         ir_q        <= '0;
         req_q       <= 1'b0;
         ir_valid_q  <= 1'b0;
         rd_sel_q    <= '0;
         halted_q    <= 1'b0;
         stack_err_q <= 1'b0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         flag_pend_q <= 1'b0;
      end else begin
         ir_valid_q  <= 1'b0;
         flag_pend_q <= 1'b0;
         // Core flags reflect an issued word one cycle after its ISSUE.
         if (flag_pend_q) begin
            z_q <= Z;
            n_q <= N;
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_FETCH;
                  req_q   <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  ir_q     <= imem_rdata;
                  rd_sel_q <= imem_rdata[5:3];
                  req_q    <= 1'b0;
                  state_q  <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (flow == FL_NONE) begin
                  ir_valid_q <= 1'b1;
                  state_q    <= ST_ISSUE;
               end else if (flow == FL_HALT || stk_fault) begin
                  halted_q <= 1'b1;
                  if (stk_fault) stack_err_q <= 1'b1;
                  state_q  <= ST_HALT;
               end else begin
                  pc_q    <= flow_pc_d;
                  req_q   <= cont;
                  state_q <= cont ? ST_FETCH : ST_IDLE;
               end
            end
            ST_ISSUE: begin
               pc_q        <= pc_inc;
               flag_pend_q <= 1'b1;
               req_q       <= cont;
               state_q     <= cont ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: ;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_q;
   assign IR        = ir_q;
   assign ir_valid  = ir_valid_q;
   assign rd_sel    = rd_sel_q;
   assign pc        = pc_q;
   assign halted    = halted_q;
   assign stack_err = stack_err_q;

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;

   logic        clock_50 = 1'b0;
   logic        reset_n  = 1'b0;
   logic        run      = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
   logic        step     = 1'b0;
`endif
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata = 16'h0;
   logic        imem_ack   = 1'b0;
   logic [15:0] IR;
   logic        ir_valid;
   logic        Z = 1'b0, N = 1'b0;
   logic [2:0]  rd_sel;
   logic [15:0] rd_data = 16'h0;
   logic [7:0]  pc;
   logic        halted, stack_err;

   logic [15:0] mem [256];
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   logic        stray_ack = 1'b0;
   int          checks = 0;
   int          errors = 0;

   core_sequencer #(.PC_W(8), .STACK_DEPTH(8)) dut (
      .clock_50   (clock_50),
      .reset_n    (reset_n),
      .run        (run),
`ifdef SEQ_SINGLE_STEP_EN
      .step       (step),
`endif
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .IR         (IR),
      .ir_valid   (ir_valid),
      .Z          (Z),
      .N          (N),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .pc         (pc),
      .halted     (halted),
      .stack_err  (stack_err)
   );

   always #10 clock_50 = ~clock_50;

   // Instruction memory: acks after ack_delay wait cycles; a stray ack
   // (request low) carries the HALT word so accepting it would be visible.
   always @(negedge clock_50) begin
      if (imem_req && wait_cnt >= ack_delay) begin
         imem_ack   = 1'b1;
         imem_rdata = mem[imem_addr];
      end else begin
         imem_ack   = stray_ack;
         imem_rdata = 16'hFFFF;
      end
      if (imem_req) wait_cnt = wait_cnt + 1;
      else          wait_cnt = 0;
   end

   task automatic do_reset();
      reset_n = 1'b0;
      run     = 1'b0;
      repeat (2) @(negedge clock_50);
      reset_n = 1'b1;
   endtask

   // Runs exactly one instruction: run rises in IDLE and falls during FETCH.
   task automatic exec_one(output int ivs);
      ivs = 0;
      run = 1'b1;
      @(negedge clock_50);
      run = 1'b0;
      repeat (14) begin
         @(negedge clock_50);
         if (ir_valid) ivs++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({imem_req, ir_valid, halted, stack_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got req/iv/halt/err=%b expected 0000",
                  {imem_req, ir_valid, halted, stack_err});
      end
      checks++;
      if ({pc, imem_addr, IR, rd_sel} !== 35'h0) begin
         errors++;
         $display("FAIL reset_values: got pc=%0h addr=%0h IR=%0h rd_sel=%0h expected 0",
                  pc, imem_addr, IR, rd_sel);
      end
   endtask

   task automatic test_core_issue();
      int first_cyc, pulses;
      logic [15:0] ir_seen;
      do_reset();
      mem[0] = 16'b0000100100000001;
      first_cyc = 0; pulses = 0; ir_seen = 16'h0;
      run = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock_50);
         if (ir_valid) begin
            pulses++;
            if (first_cyc == 0) begin
               first_cyc = c;
               ir_seen   = IR;
               run       = 1'b0;
            end
         end
      end
      checks++;
      if (first_cyc !== 3) begin
         errors++;
         $display("FAIL issue_latency: got cycle %0d expected 3", first_cyc);
      end
      checks++;
      if (ir_seen !== 16'h0901 || pulses !== 1) begin
         errors++;
         $display("FAIL issue_ir: got IR=%0h pulses=%0d expected 0901 and 1", ir_seen, pulses);
      end
      checks++;
      if (pc !== 8'h01 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL issue_pc: got pc=%0h req=%b expected 01 and 0", pc, imem_req);
      end
   endtask

   task automatic test_branch();
      int iv;
      for (int t = 0; t < 2; t++) begin
         do_reset();
         Z = (t == 1); N = 1'b0;
         for (int i = 0; i < 5; i++) mem[i] = 16'h0000;
         mem[5] = 16'hB0FE;
         for (int i = 0; i < 5; i++) exec_one(iv);
         exec_one(iv);
         checks++;
         if (pc !== ((t == 1) ? 8'h04 : 8'h06) || iv !== 0) begin
            errors++;
            $display("FAIL brz_z%0d: got pc=%0h ir_valid_pulses=%0d expected %0h and 0",
                     t, pc, iv, (t == 1) ? 8'h04 : 8'h06);
         end
      end
      // n_q is only latched after an issued word, so the first BRN sees 0.
      do_reset();
      Z = 1'b0; N = 1'b1;
      mem[0] = 16'hB8F0; mem[1] = 16'h0000; mem[2] = 16'hB8F0;
      exec_one(iv);
      checks++;
      if (pc !== 8'h01) begin
         errors++;
         $display("FAIL brn_reset_flag: got pc=%0h expected 01", pc);
      end
      exec_one(iv);
      exec_one(iv);
      checks++;
      if (pc !== 8'hF3 || iv !== 0) begin
         errors++;
         $display("FAIL brn_wrap: got pc=%0h pulses=%0d expected f3 and 0", pc, iv);
      end
      N = 1'b0;
   endtask

   task automatic test_call_ret();
      int iv;
      do_reset();
      for (int i = 0; i < 3; i++) mem[i] = 16'h0000;
      mem[3]     = 16'h9C18;
      mem[8'h40] = 16'h9E00;
      mem[4]     = 16'h9A00;
      rd_data    = 16'h0040;
      for (int i = 0; i < 3; i++) exec_one(iv);
      exec_one(iv);
      checks++;
      if (pc !== 8'h40 || rd_sel !== 3'd3 || iv !== 0) begin
         errors++;
         $display("FAIL call: got pc=%0h rd_sel=%0d pulses=%0d expected 40, 3, 0", pc, rd_sel, iv);
      end
      exec_one(iv);
      checks++;
      if (pc !== 8'h04) begin
         errors++;
         $display("FAIL ret: got pc=%0h expected 04", pc);
      end
      rd_data = 16'hAB37;
      exec_one(iv);
      checks++;
      if (pc !== 8'h37 || stack_err !== 1'b0) begin
         errors++;
         $display("FAIL jmpr: got pc=%0h err=%b expected 37 and 0", pc, stack_err);
      end
   endtask

   task automatic test_stack_overflow();
      int iv, reqs;
      do_reset();
      mem[0]  = 16'h9C00;
      rd_data = 16'h0000;
      repeat (8) exec_one(iv);
      checks++;
      if (stack_err !== 1'b0 || halted !== 1'b0 || pc !== 8'h00) begin
         errors++;
         $display("FAIL stack_full_ok: got err=%b halted=%b pc=%0h expected 0 0 00",
                  stack_err, halted, pc);
      end
      exec_one(iv);
      checks++;
      if (stack_err !== 1'b1 || halted !== 1'b1 || pc !== 8'h00) begin
         errors++;
         $display("FAIL stack_overflow: got err=%b halted=%b pc=%0h expected 1 1 00",
                  stack_err, halted, pc);
      end
      reqs = 0;
      run  = 1'b1;
      repeat (10) begin
         @(negedge clock_50);
         if (imem_req) reqs++;
      end
      run = 1'b0;
      checks++;
      if (reqs !== 0) begin
         errors++;
         $display("FAIL overflow_no_fetch: got %0d request cycles expected 0", reqs);
      end
   endtask

   task automatic test_stack_underflow();
      int iv;
      do_reset();
      mem[0] = 16'h9E00;
      exec_one(iv);
      checks++;
      if (stack_err !== 1'b1 || halted !== 1'b1 || pc !== 8'h00) begin
         errors++;
         $display("FAIL stack_underflow: got err=%b halted=%b pc=%0h expected 1 1 00",
                  stack_err, halted, pc);
      end
   endtask

   task automatic test_halt();
      int iv, reqs;
      do_reset();
      mem[0] = 16'hFFFF;
      exec_one(iv);
      checks++;
      if (halted !== 1'b1 || stack_err !== 1'b0 || iv !== 0) begin
         errors++;
         $display("FAIL halt_word: got halted=%b err=%b pulses=%0d expected 1 0 0",
                  halted, stack_err, iv);
      end
      reqs = 0;
      run  = 1'b1;
      repeat (10) begin
         @(negedge clock_50);
         if (imem_req) reqs++;
      end
      run = 1'b0;
      checks++;
      if (reqs !== 0 || pc !== 8'h00) begin
         errors++;
         $display("FAIL halt_ignores_run: got reqs=%0d pc=%0h expected 0 and 00", reqs, pc);
      end
   endtask

   task automatic test_ack_delay();
      int req_cycles, pulses;
      logic stable;
      logic [7:0] addr0;
      do_reset();
      ack_delay = 4;
      mem[0] = 16'h1234;
      req_cycles = 0; pulses = 0; stable = 1'b1; addr0 = 8'h00;
      run = 1'b1;
      repeat (12) begin
         @(negedge clock_50);
         if (ir_valid) pulses++;
         if (imem_req) begin
            if (req_cycles == 0) addr0 = imem_addr;
            else if (imem_addr !== addr0) stable = 1'b0;
            req_cycles++;
            run = 1'b0;
         end
      end
      checks++;
      if (req_cycles !== 5 || stable !== 1'b1 || addr0 !== 8'h00) begin
         errors++;
         $display("FAIL ack_wait_req: got req_cycles=%0d stable=%b addr=%0h expected 5 1 00",
                  req_cycles, stable, addr0);
      end
      checks++;
      if (pc !== 8'h01 || IR !== 16'h1234 || pulses !== 1 || rd_sel !== 3'd6) begin
         errors++;
         $display("FAIL ack_wait_exec: got pc=%0h IR=%0h pulses=%0d rd_sel=%0d expected 01 1234 1 6",
                  pc, IR, pulses, rd_sel);
      end
   endtask

   task automatic test_reset_mid_fetch();
      ack_delay = 10;
      run = 1'b1;
      @(negedge clock_50);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
         errors++;
         $display("FAIL mid_fetch_setup: got req=%b addr=%0h expected 1 and 01", imem_req, imem_addr);
      end
      reset_n = 1'b0;
      @(negedge clock_50);
      checks++;
      if ({imem_req, ir_valid, halted, stack_err} !== 4'b0000 ||
          {pc, imem_addr, IR, rd_sel} !== 35'h0) begin
         errors++;
         $display("FAIL mid_fetch_reset: got req=%b iv=%b pc=%0h addr=%0h IR=%0h rd_sel=%0h expected all 0",
                  imem_req, ir_valid, pc, imem_addr, IR, rd_sel);
      end
      reset_n   = 1'b1;
      run       = 1'b0;
      ack_delay = 0;
      stray_ack = 1'b1;
      repeat (3) @(negedge clock_50);
      stray_ack = 1'b0;
      repeat (2) @(negedge clock_50);
      checks++;
      if (IR !== 16'h0000 || pc !== 8'h00 || halted !== 1'b0 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL late_ack_ignored: got IR=%0h pc=%0h halted=%b req=%b expected 0000 00 0 0",
                  IR, pc, halted, imem_req);
      end
   endtask

`ifdef SEQ_SINGLE_STEP_EN
   task automatic test_single_step();
      int pulses;
      do_reset();
      mem[0] = 16'h0000; mem[1] = 16'h0000;
      for (int s = 1; s <= 2; s++) begin
         pulses = 0;
         step = 1'b1;
         @(negedge clock_50);
         step = 1'b0;
         repeat (12) begin
            @(negedge clock_50);
            if (ir_valid) pulses++;
         end
         checks++;
         if (pulses !== 1 || pc !== 8'(s) || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL single_step_%0d: got pulses=%0d pc=%0h req=%b expected 1 %0h 0",
                     s, pulses, pc, imem_req, s);
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      test_reset();
      test_core_issue();
      test_branch();
      test_call_ret();
      test_stack_overflow();
      test_stack_underflow();
      test_halt();
      test_ack_delay();
      test_reset_mid_fetch();
`ifdef SEQ_SINGLE_STEP_EN
      test_single_step();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
